// File: rtl/rr_arb_mux.sv
// Round-robin arbitrated N:1 multiplexer with a registered output stage.
// Shares one downstream valid/ready port among NCH requesters, optional grant lock.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 lock,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Handshake: a word moves on a rising edge where valid and ready are both
  // high. Ready never looks at data, and a requester may drop valid before it
  // is accepted; nothing is remembered about a request that was withdrawn.

  localparam int              NPAD    = 1 << SELW;
  localparam logic [SELW:0]   NCH_W   = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  logic [SELW-1:0]  r_ptr;
  logic [SELW-1:0]  r_last;
  logic [SELW-1:0]  r_sel;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic [NPAD-1:0]  w_valid_pad;
  logic             w_space;
  logic             w_grant_vld;
  logic             w_accept;
  logic [SELW-1:0]  w_grant;
  logic [SELW:0]    w_idx;
  logic [WIDTH-1:0] w_sel_data;

  // Padding to a power of two keeps every SELW-bit index in range.
  assign w_valid_pad = NPAD'(in_valid);
  assign w_space     = !r_valid || out_ready;
  assign w_accept    = w_space && w_grant_vld;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_idx       = '0;
    if (lock && w_valid_pad[r_last]) begin
      w_grant_vld = 1'b1;
      w_grant     = r_last;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        w_idx = {1'b0, r_ptr} + (SELW+1)'(k);
        if (w_idx >= NCH_W) begin
          w_idx = w_idx - NCH_W;
        end
        if (!w_grant_vld && w_valid_pad[w_idx[SELW-1:0]]) begin
          w_grant_vld = 1'b1;
          w_grant     = w_idx[SELW-1:0];
        end
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    in_ready   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant == SELW'(i)) begin
        w_sel_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = w_space && w_grant_vld;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_last  <= '0;
      r_sel   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= w_sel_data;
      r_sel   <= w_grant;
      r_valid <= 1'b1;
      r_last  <= w_grant;
      // The pointer moves even under lock so rotation resumes past the winner.
      r_ptr   <= (w_grant == LAST_CH) ? '0 : w_grant + SELW'(1);
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a 4-channel instance for the main scenarios and a
// 3-channel instance for pointer wrap; expected words flow through queues.
module tb_rr_arb_mux;

  localparam int W4 = 32;
  localparam int N4 = 4;
  localparam int S4 = 2;
  localparam int W3 = 8;
  localparam int N3 = 3;
  localparam int S3 = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N4*W4-1:0] in_data4;
  logic [N4-1:0]    in_valid4;
  logic [N4-1:0]    in_ready4;
  logic             lock4;
  logic [W4-1:0]    out_data4;
  logic [S4-1:0]    out_sel4;
  logic             out_valid4;
  logic             out_ready4;

  logic [N3*W3-1:0] in_data3;
  logic [N3-1:0]    in_valid3;
  logic [N3-1:0]    in_ready3;
  logic             lock3;
  logic [W3-1:0]    out_data3;
  logic [S3-1:0]    out_sel3;
  logic             out_valid3;
  logic             out_ready3;

  int total = 0;
  int bad = 0;

  logic [S4+W4-1:0] exp_q[$];
  logic [S3+W3-1:0] exp3_q[$];
  logic [S4+W4-1:0] e4;
  logic [S3+W3-1:0] e3;

  rr_arb_mux #(.WIDTH(W4), .NCH(N4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .lock      (lock4),
    .out_data  (out_data4),
    .out_sel   (out_sel4),
    .out_valid (out_valid4),
    .out_ready (out_ready4)
  );

  rr_arb_mux #(.WIDTH(W3), .NCH(N3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .lock      (lock3),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  // scoreboards: a word leaves the DUT on a negedge where valid && ready hold
  always @(negedge clk) begin
    if (rst_n && out_valid4 && out_ready4) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb4_unexpected: got sel=%0d data=%0h, want no word", out_sel4, out_data4);
      end else begin
        e4 = exp_q.pop_front();
        if ({out_sel4, out_data4} !== e4) begin
          bad++;
          $display("FAIL sb4_word: got sel=%0d data=%0h, want sel=%0d data=%0h",
                   out_sel4, out_data4, e4[S4+W4-1:W4], e4[W4-1:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid3 && out_ready3) begin
      total++;
      if (exp3_q.size() == 0) begin
        bad++;
        $display("FAIL sb3_unexpected: got sel=%0d data=%0h, want no word", out_sel3, out_data3);
      end else begin
        e3 = exp3_q.pop_front();
        if ({out_sel3, out_data3} !== e3) begin
          bad++;
          $display("FAIL sb3_word: got sel=%0d data=%0h, want sel=%0d data=%0h",
                   out_sel3, out_data3, e3[S3+W3-1:W3], e3[W3-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid4 = '0; lock4 = 1'b0; out_ready4 = 1'b0;
    in_valid3 = '0; lock3 = 1'b0; out_ready3 = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    exp3_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_data4 = '0; in_valid4 = '0; lock4 = 1'b0; out_ready4 = 1'b0;
    in_data3 = '0; in_valid3 = '0; lock3 = 1'b0; out_ready3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({out_valid4, out_sel4, out_data4} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%0b sel=%0d data=%0h, want all 0", out_valid4, out_sel4, out_data4);
    end
    total++;
    if (in_ready4 !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ready: got %b want 0000", in_ready4);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_data4[3*W4 +: W4] = 32'h33;
    in_valid4 = 4'b1000;
    exp_q.push_back({2'd3, 32'h33});
    @(negedge clk);
    total++;
    if (in_ready4 !== 4'b1000) begin
      bad++;
      $display("FAIL reset_pre_ready: got %b want 1000", in_ready4);
    end
    @(posedge clk); #1;
    in_valid4 = '0;
    @(negedge clk);
    total++;
    if ({out_valid4, out_sel4, out_data4} !== {1'b1, 2'd3, 32'h33}) begin
      bad++;
      $display("FAIL reset_held_word: got v=%0b sel=%0d data=%0h, want v=1 sel=3 data=33",
               out_valid4, out_sel4, out_data4);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid4, out_sel4, out_data4} !== '0) begin
      bad++;
      $display("FAIL async_reset: got v=%0b sel=%0d data=%0h, want all 0", out_valid4, out_sel4, out_data4);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_data4[0 +: W4] = 32'hA5;
    in_valid4 = 4'b0001;
    out_ready4 = 1'b1;
    exp_q.push_back({2'd0, 32'hA5});
    @(negedge clk);
    total++;
    if (in_ready4 !== 4'b0001) begin
      bad++;
      $display("FAIL reset_a5_ready: got %b want 0001", in_ready4);
    end
    @(posedge clk); #1;
    in_valid4 = '0;
    @(negedge clk);
    total++;
    if ({out_valid4, out_sel4, out_data4} !== {1'b1, 2'd0, 32'hA5}) begin
      bad++;
      $display("FAIL reset_first_word: got v=%0b sel=%0d data=%0h, want v=1 sel=0 data=a5",
               out_valid4, out_sel4, out_data4);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({out_valid4, out_sel4, out_data4} !== {1'b0, 2'd0, 32'hA5}) begin
      bad++;
      $display("FAIL drain_hold: got v=%0b sel=%0d data=%0h, want v=0 sel=0 data=a5",
               out_valid4, out_sel4, out_data4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [1:0] c;
    apply_reset();
    for (int i = 0; i < N4; i++) in_data4[i*W4 +: W4] = 32'h10 + 32'(i);
    in_valid4 = 4'hF;
    out_ready4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c = 2'(i % 4);
      exp_q.push_back({c, 32'h10 + 32'(c)});
      @(negedge clk);
      total++;
      if (in_ready4 !== 4'(1 << c)) begin
        bad++;
        $display("FAIL rr_ready: step %0d got %b want %b", i, in_ready4, 4'(1 << c));
      end
      if (i > 0) begin
        total++;
        if (out_valid4 !== 1'b1) begin
          bad++;
          $display("FAIL rr_no_bubble: step %0d got out_valid=%b want 1", i, out_valid4);
        end
      end
      @(posedge clk); #1;
    end
    in_valid4 = '0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    in_valid4 = 4'b0010;
    out_ready4 = 1'b0;
    exp_q.push_back({2'd1, 32'h11});
    @(negedge clk);
    total++;
    if (in_ready4 !== 4'b0010) begin
      bad++;
      $display("FAIL bp_first_ready: got %b want 0010", in_ready4);
    end
    @(posedge clk); #1;
    in_valid4 = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid4, out_sel4, out_data4} !== {1'b1, 2'd1, 32'h11}) begin
        bad++;
        $display("FAIL bp_frozen: cycle %0d got v=%0b sel=%0d data=%0h, want v=1 sel=1 data=11",
                 i, out_valid4, out_sel4, out_data4);
      end
      total++;
      if (in_ready4 !== 4'b0000) begin
        bad++;
        $display("FAIL bp_no_ready: cycle %0d got %b want 0000", i, in_ready4);
      end
      @(posedge clk); #1;
    end
    out_ready4 = 1'b1;
    exp_q.push_back({2'd2, 32'h12});
    @(negedge clk);
    total++;
    if (in_ready4 !== 4'b0100) begin
      bad++;
      $display("FAIL bp_resume_grant: got %b want 0100", in_ready4);
    end
    @(posedge clk); #1;
    in_valid4 = '0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_lock();
    logic [3:0] vtab [6] = '{4'b0010, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
    logic       ltab [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int         ctab [6] = '{1, 1, 1, 1, 2, 1};
    out_ready4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid4 = vtab[i];
      lock4 = ltab[i];
      exp_q.push_back({2'(ctab[i]), 32'h10 + 32'(ctab[i])});
      @(negedge clk);
      total++;
      if (in_ready4 !== 4'(1 << ctab[i])) begin
        bad++;
        $display("FAIL lock_ready: step %0d got %b want %b", i, in_ready4, 4'(1 << ctab[i]));
      end
      @(posedge clk); #1;
    end
    in_valid4 = '0;
    lock4 = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_drop_before_accept();
    in_valid4 = 4'b0001;
    out_ready4 = 1'b0;
    exp_q.push_back({2'd0, 32'h10});
    @(negedge clk);
    total++;
    if (in_ready4 !== 4'b0001) begin
      bad++;
      $display("FAIL drop_first_ready: got %b want 0001", in_ready4);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid4 = (i < 2) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      total++;
      if ({in_ready4, out_sel4} !== {4'b0000, 2'd0}) begin
        bad++;
        $display("FAIL drop_stalled: cycle %0d got ready=%b sel=%0d, want ready=0000 sel=0",
                 i, in_ready4, out_sel4);
      end
      @(posedge clk); #1;
    end
    out_ready4 = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready4 !== 4'b0000) begin
      bad++;
      $display("FAIL drop_release_ready: got %b want 0000", in_ready4);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({out_valid4, out_sel4} !== {1'b0, 2'd0}) begin
      bad++;
      $display("FAIL drop_never_granted: got v=%0b sel=%0d, want v=0 sel=0", out_valid4, out_sel4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sparse_wrap();
    int ctab [4] = '{0, 2, 0, 2};
    apply_reset();
    in_data3 = {8'hC2, 8'hC1, 8'hC0};
    in_valid3 = 3'b101;
    out_ready3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp3_q.push_back({2'(ctab[i]), 8'hC0 + 8'(ctab[i])});
      @(negedge clk);
      total++;
      if (in_ready3 !== 3'(1 << ctab[i])) begin
        bad++;
        $display("FAIL wrap_ready: step %0d got %b want %b", i, in_ready3, 3'(1 << ctab[i]));
      end
      @(posedge clk); #1;
    end
    in_valid3 = '0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (out_valid3 !== 1'b0) begin
      bad++;
      $display("FAIL wrap_drain: got out_valid=%b want 0", out_valid3);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_lock();
    test_drop_before_accept();
    test_sparse_wrap();
    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb4_leftover: got %0d pending words want 0", exp_q.size());
    end
    total++;
    if (exp3_q.size() != 0) begin
      bad++;
      $display("FAIL sb3_leftover: got %0d pending words want 0", exp3_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
